fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Read side of the framebuffer. The tile renderer writes RGB565 pixels at address y*640+x; this block reads them back in raster order and drives the VGA port.
- Generates 640x480@60 timing from a pixel-tick enable and issues one framebuffer read per active pixel.
- Converts RGB565 to RGB444 and outputs hs, vs and rgb aligned to each other.
- Exports vblank and frame_start so the renderer can schedule tile writes outside active scan.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- ADDR_W, 19, framebuffer address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_en  in  1  pixel tick, one clk wide; at least 2 clk between ticks
- src_addr  out  ADDR_W  framebuffer read address
- src_rd  out  1  read strobe, high for one clk on active-pixel ticks
- src_data  in  16  RGB565 read data, valid 1 clk after src_addr/src_rd
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- de  out  1  display enable
- rgb  out  12  {R4,G4,B4}
- vblank  out  1  high while vcnt >= V_ACTIVE (counter stage)
- frame_start  out  1  one-clk pulse on the tick where counters wrap to (0,0)

Behaviour:
- Reset values: all outputs 0, except hs=1 and vs=1. Counters hcnt=0, vcnt=0, line_base=0.
- Counters (stage 0), advance only on pix_en:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL=800.
  - On hcnt wrap, vcnt runs 0..V_TOTAL-1, where V_TOTAL=525.
  - Between ticks, all state holds.
- Address generation without a multiplier:
  - line_base += H_ACTIVE on hcnt wrap when the line just finished was active (vcnt < V_ACTIVE).
  - line_base clears to 0 when vcnt wraps.
  - Address = line_base + hcnt, computed in ADDR_W bits. The maximum is 307199, so it never overflows 19 bits.
- Stage 1, registered on pix_en from stage-0 values:
  - src_addr = line_base + hcnt when active; otherwise src_addr holds its previous value.
  - src_rd = 1 for one clk iff hcnt < H_ACTIVE and vcnt < V_ACTIVE.
  - Internal hs1, vs1 and de1 are registered at the same time.
- Stage 2, registered on the next pix_en:
  - rgb = de1 ? {src_data[15:12], src_data[10:7], src_data[4:1]} : 0.
  - hs = hs1, vs = vs1, de = de1.
- Sync decode (stage 0):
  - hs1 = 0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs1 = 0 iff vcnt is in 490..491.
- Latency: the outputs for pixel (h,v) appear exactly 2 pix_en ticks after the counters hold (h,v). hs, vs, de and rgb are therefore mutually aligned.
- frame_start and vblank come from stage 0 and are not delayed. Consumers treat them as early indications.
- Boundaries:
  - End of line 479 (hcnt 799 → 0, vcnt 479 → 480): vblank rises and line_base stops advancing.
  - vcnt 524 → 0: frame_start pulses and vblank falls on that same tick.
  - pix_en stuck at 0: all outputs frozen, no reads issued.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The first tick after release processes (0,0). No partial-frame state survives.
- src_data is sampled only on pix_en ticks. A pix_en spacing below 2 clk is a usage error; no detection is required.

Decomposition:
- Shared video-timing package: 640x480 timing constants, H_TOTAL/V_TOTAL derivations, and the RGB565→RGB444 conversion function.
- One natural sub-module: vga_timing_gen (hcnt, vcnt, hs1, vs1, active, vblank, frame_start).
- Address generation, stage 1 and stage 2 stay in fb_scanout.

Test Plan:
- Reset, then pix_en every 4 clk:
  - First src_rd with src_addr=0 on the first tick.
  - de rises 2 ticks later.
  - Full line gives 640 src_rd pulses and hs low for exactly 96 ticks, starting 656 ticks after de rose.
- Framebuffer model returns data=addr[15:0] (1-clk latency):
  - Pixel (x=5, y=2) yields src_addr=1285 and rgb={data[15:12],data[10:7],data[4:1]} for data=0x0505.
- Full frame:
  - Exactly 307200 src_rd pulses and last src_addr=307199.
  - vs low for 2 lines (vcnt 490–491); vblank high for 45 lines.
  - frame_start pulses once every 420000 ticks.
- Frozen pix_en: hold pix_en=0 for 100 clk mid-line → src_rd stays 0, all outputs unchanged, and scanning resumes at the same hcnt.
- Mid-frame reset: assert rst at (hcnt=300, vcnt=200) → outputs go to reset values asynchronously. After release, the next src_addr is 0 and de stays 0 until stage 2 fills.
- Blanking content: force src_data=0xFFFF throughout → rgb=0xFFF only while de=1 and rgb=0 everywhere else.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_scanout_pkg
// Purpose  : 640x480@60 video timing constants and RGB565 -> RGB444 helper.
// Revision : 1.0
// ============================================================================
package fb_scanout_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_ADDR_W   = 19;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Keep the top nibble of each channel, dropping the extra green bit too.
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] pix);
        return {pix[15:12], pix[10:7], pix[4:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Stage-0 raster counters and combinational sync/active decode.
// Revision : 1.0
// ============================================================================
module vga_timing_gen
    import fb_scanout_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    output logic [H_W-1:0] hcnt,
    output logic [V_W-1:0] vcnt,
    output logic           hsync_n,
    output logic           vsync_n,
    output logic           active,
    output logic           vblank,
    output logic           line_end,
    output logic           v_last,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] c_h_last     = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] c_v_last     = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] c_h_act      = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] c_v_act      = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] c_hs_start   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] c_hs_end     = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] c_vs_start   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] c_vs_end     = V_W'(V_ACTIVE + V_FP + V_SYNC);

    assign line_end = (hcnt == c_h_last);
    assign v_last   = (vcnt == c_v_last);
    assign active   = (hcnt < c_h_act) && (vcnt < c_v_act);
    assign vblank   = (vcnt >= c_v_act);
    assign hsync_n  = !((hcnt >= c_hs_start) && (hcnt < c_hs_end));
    assign vsync_n  = !((vcnt >= c_vs_start) && (vcnt < c_vs_end));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                if (line_end) begin
                    hcnt <= '0;
                    if (v_last) begin
                        vcnt        <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        vcnt <= vcnt + 1'b1;
                    end
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : fb_scanout
// Purpose  : Framebuffer read-back in raster order driving a 2-stage VGA port.
// Revision : 1.0
// ============================================================================
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_rd,
    input  logic [15:0]       src_data,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [11:0]       rgb,
    output logic              vblank,
    output logic              frame_start
);

    localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [H_W-1:0]    w_hcnt;
    logic [V_W-1:0]    w_vcnt;
    logic              w_hsync_n;
    logic              w_vsync_n;
    logic              w_active;
    logic              w_line_end;
    logic              w_v_last;
    logic [ADDR_W-1:0] w_addr;

    logic [ADDR_W-1:0] r_line_base;
    logic              r_hs1;
    logic              r_vs1;
    logic              r_de1;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hcnt        (w_hcnt),
        .vcnt        (w_vcnt),
        .hsync_n     (w_hsync_n),
        .vsync_n     (w_vsync_n),
        .active      (w_active),
        .vblank      (vblank),
        .line_end    (w_line_end),
        .v_last      (w_v_last),
        .frame_start (frame_start)
    );

    // Running line base replaces the y*640 multiply.
    assign w_addr = r_line_base + ADDR_W'(w_hcnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_base <= '0;
            src_addr    <= '0;
            src_rd      <= 1'b0;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_de1       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
        end else begin
            src_rd <= 1'b0;
            if (pix_en) begin
                if (w_line_end) begin
                    if (w_v_last) begin
                        r_line_base <= '0;
                    end else if (!vblank) begin
                        r_line_base <= r_line_base + ADDR_W'(H_ACTIVE);
                    end
                end

                src_rd <= w_active;
                if (w_active) begin
                    src_addr <= w_addr;
                end
                r_hs1 <= w_hsync_n;
                r_vs1 <= w_vsync_n;
                r_de1 <= w_active;

                // src_data answers the read issued on the previous tick.
                rgb <= r_de1 ? rgb565_to_444(src_data) : 12'h000;
                hs  <= r_hs1;
                vs  <= r_vs1;
                de  <= r_de1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_scanout
// Purpose  : Self-checking bench: full-size and shrunken-timing scanout DUTs.
// Revision : 1.0
// ============================================================================
module tb_fb_scanout;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    logic ff_mode = 1'b0;

    always #5 clk = ~clk;

    logic [18:0] b_addr, s_addr;
    logic        b_rd, s_rd;
    logic [15:0] b_data, s_data;
    logic        b_hs, s_hs, b_vs, s_vs, b_de, s_de;
    logic [11:0] b_rgb, s_rgb;
    logic        b_vb, s_vb, b_fs, s_fs;

    fb_scanout u_big (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .src_addr(b_addr), .src_rd(b_rd), .src_data(b_data),
        .hs(b_hs), .vs(b_vs), .de(b_de), .rgb(b_rgb),
        .vblank(b_vb), .frame_start(b_fs)
    );

    fb_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .ADDR_W(19)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .src_addr(s_addr), .src_rd(s_rd), .src_data(s_data),
        .hs(s_hs), .vs(s_vs), .de(s_de), .rgb(s_rgb),
        .vblank(s_vb), .frame_start(s_fs)
    );

    // Framebuffer models: one clk read latency, data = address or all-ones.
    always @(posedge clk) begin
        b_data <= ff_mode ? 16'hFFFF : b_addr[15:0];
        s_data <= ff_mode ? 16'hFFFF : s_addr[15:0];
    end

    // ---------------- reference model (tick index arithmetic) ----------------
    function automatic int hta(int d); return d == 0 ? 640 : 8; endfunction
    function automatic int hfp(int d); return d == 0 ? 16  : 2; endfunction
    function automatic int hsy(int d); return d == 0 ? 96  : 3; endfunction
    function automatic int hbp(int d); return d == 0 ? 48  : 3; endfunction
    function automatic int vta(int d); return d == 0 ? 480 : 4; endfunction
    function automatic int vfp(int d); return d == 0 ? 10  : 1; endfunction
    function automatic int vsy(int d); return d == 0 ? 2   : 2; endfunction
    function automatic int vbp(int d); return d == 0 ? 33  : 2; endfunction
    function automatic int ht(int d); return hta(d) + hfp(d) + hsy(d) + hbp(d); endfunction
    function automatic int vt(int d); return vta(d) + vfp(d) + vsy(d) + vbp(d); endfunction
    function automatic int hpos(int d, int t); return t % ht(d); endfunction
    function automatic int vpos(int d, int t); return (t / ht(d)) % vt(d); endfunction
    function automatic bit act(int d, int t);
        return (hpos(d, t) < hta(d)) && (vpos(d, t) < vta(d));
    endfunction
    function automatic int paddr(int d, int t);
        return vpos(d, t) * hta(d) + hpos(d, t);
    endfunction
    function automatic bit hs_n(int d, int t);
        int h = hpos(d, t);
        return !((h >= hta(d) + hfp(d)) && (h < hta(d) + hfp(d) + hsy(d)));
    endfunction
    function automatic bit vs_n(int d, int t);
        int v = vpos(d, t);
        return !((v >= vta(d) + vfp(d)) && (v < vta(d) + vfp(d) + vsy(d)));
    endfunction
    function automatic logic [11:0] conv(logic [15:0] x);
        return {x[15:12], x[10:7], x[4:1]};
    endfunction

    int k = 0;          // pixel ticks processed since reset release
    bit last_tick = 0;  // the previous clk edge carried a tick
    int exp_addr [2];
    bit mode_hist [8192];

    always @(posedge clk) begin
        if (rst) begin
            k           <= 0;
            last_tick   <= 1'b0;
            exp_addr[0] <= 0;
            exp_addr[1] <= 0;
        end else begin
            last_tick <= pix_en;
            if (pix_en) begin
                k <= k + 1;
                for (int d = 0; d < 2; d++)
                    if (act(d, k)) exp_addr[d] <= paddr(d, k);
            end
            if (last_tick) mode_hist[(k - 1) % 8192] <= ff_mode;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] actv, input logic [31:0] expv);
        total++;
        if (actv !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)", nm, actv, expv, $time, k);
        end
    endtask

    task automatic check_dut(input int d, input string t, input logic [18:0] a, input logic rd,
                             input logic hsv, input logic vsv, input logic dev,
                             input logic [11:0] rg, input logic vb, input logic fs);
        int p;
        logic [15:0] dat;
        logic e_de;
        if (rst) begin
            chk({t, "_rd"}, rd, 0);   chk({t, "_addr"}, a, 0);
            chk({t, "_hs"}, hsv, 1);  chk({t, "_vs"}, vsv, 1);
            chk({t, "_de"}, dev, 0);  chk({t, "_rgb"}, rg, 0);
            chk({t, "_vblank"}, vb, 0); chk({t, "_fs"}, fs, 0);
        end else begin
            chk({t, "_rd"}, rd, (last_tick && k > 0) ? act(d, k - 1) : 1'b0);
            chk({t, "_addr"}, a, exp_addr[d]);
            chk({t, "_vblank"}, vb, vpos(d, k) >= vta(d));
            chk({t, "_fs"}, fs, last_tick && k > 0 && (k % (ht(d) * vt(d))) == 0);
            if (k < 2) begin
                chk({t, "_hs"}, hsv, 1); chk({t, "_vs"}, vsv, 1);
                chk({t, "_de"}, dev, 0); chk({t, "_rgb"}, rg, 0);
            end else begin
                p    = k - 2;
                e_de = act(d, p);
                dat  = mode_hist[p % 8192] ? 16'hFFFF : 16'(paddr(d, p));
                chk({t, "_hs"}, hsv, hs_n(d, p));
                chk({t, "_vs"}, vsv, vs_n(d, p));
                chk({t, "_de"}, dev, e_de);
                chk({t, "_rgb"}, rg, e_de ? conv(dat) : 12'h000);
            end
        end
    endtask

    int b_rd_cnt = 0, b_hs_low = 0, de_rise_k = -1, hs_fall_k = -1;
    int s_rd_cnt = 0, s_fs_cnt = 0, s_vs_low = 0, s_vb_cnt = 0;
    int fs_k_prev = 0, fs_k_last = 0, bad_blank = 0, seen_fff = 0;
    bit blank_arm = 0;

    always @(negedge clk) begin
        check_dut(0, "big", b_addr, b_rd, b_hs, b_vs, b_de, b_rgb, b_vb, b_fs);
        check_dut(1, "small", s_addr, s_rd, s_hs, s_vs, s_de, s_rgb, s_vb, s_fs);
        if (!rst) begin
            if (b_rd) b_rd_cnt++;
            if (s_rd) s_rd_cnt++;
            if (s_fs) begin
                s_fs_cnt++;
                fs_k_prev = fs_k_last;
                fs_k_last = k;
            end
            if (last_tick) begin
                if (!s_vs) s_vs_low++;
                if (s_vb) s_vb_cnt++;
                if (!b_hs) b_hs_low++;
                if (b_de && de_rise_k < 0) de_rise_k = k;
                if (!b_hs && hs_fall_k < 0) hs_fall_k = k;
                if (blank_arm) begin
                    if ((s_de && s_rgb != 12'hFFF) || (!s_de && s_rgb != 12'h000)) bad_blank++;
                    if ((b_de && b_rgb != 12'hFFF) || (!b_de && b_rgb != 12'h000)) bad_blank++;
                    if (s_de && s_rgb == 12'hFFF) seen_fff++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_ticks(input int n, input int gap);
        repeat (n) begin
            repeat (gap - 2) @(posedge clk);
            @(posedge clk); #1 pix_en = 1'b1;
            @(posedge clk); #1 pix_en = 1'b0;
        end
    endtask

    int sa, srgb, shs, svs, sde, r0, f0, v0, b0;

    initial begin
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_hs", b_hs, 1);
        chk("rst_vs", s_vs, 1);
        chk("rst_src_rd", b_rd, 0);

        run_ticks(1, 4);
        chk("first_rd", b_rd, 1);
        chk("first_addr", b_addr, 0);
        chk("first_de", b_de, 0);
        run_ticks(1, 4);
        chk("de_rise", b_de, 1);

        run_ticks(798, 4);
        chk("line_rd_cnt", b_rd_cnt, 640);
        chk("hs_low_ticks", b_hs_low, 96);
        chk("hs_after_de", hs_fall_k - de_rise_k, 656);

        run_ticks(806, 2);              // last processed pixel (5,2)
        chk("px_addr", b_addr, 1285);
        chk("px_rd", b_rd, 1);
        run_ticks(1, 2);
        chk("px_rgb", b_rgb, 12'h0A2);
        chk("px_de", b_de, 1);

        sa = b_addr; srgb = b_rgb; shs = b_hs; svs = b_vs; sde = b_de;
        repeat (100) @(posedge clk);
        #1;
        chk("frz_rd", b_rd, 0);
        chk("frz_addr", b_addr, sa);
        chk("frz_rgb", b_rgb, srgb);
        chk("frz_hs", b_hs, shs);
        chk("frz_vs", b_vs, svs);
        chk("frz_de", b_de, sde);
        run_ticks(1, 2);
        chk("resume_addr", b_addr, 1287);

        while ((k % 144) != 0) run_ticks(1, 2);
        @(negedge clk); #1;
        r0 = s_rd_cnt; f0 = s_fs_cnt; v0 = s_vs_low; b0 = s_vb_cnt;
        run_ticks(144, 2);
        @(negedge clk); #1;
        chk("frame_rd_cnt", s_rd_cnt - r0, 32);
        chk("frame_fs_cnt", s_fs_cnt - f0, 1);
        chk("frame_vs_low", s_vs_low - v0, 32);
        chk("frame_vblank", s_vb_cnt - b0, 80);
        chk("frame_last_addr", s_addr, 31);
        chk("fs_period", fs_k_last - fs_k_prev, 144);

        ff_mode = 1'b1;
        run_ticks(4, 2);
        blank_arm = 1'b1;
        run_ticks(150, 2);
        blank_arm = 1'b0;
        ff_mode = 1'b0;
        chk("blank_bad", bad_blank, 0);
        chk("blank_seen", seen_fff > 0, 1);

        while ((k % 144) != 37) run_ticks(1, 2);   // small counters at (5,2)
        #2 rst = 1'b1;
        #1;
        chk("arst_b_addr", b_addr, 0);
        chk("arst_s_addr", s_addr, 0);
        chk("arst_hs", b_hs, 1);
        chk("arst_de", s_de, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_ticks(1, 2);
        chk("post_addr", s_addr, 0);
        chk("post_rd", s_rd, 1);
        chk("post_de", s_de, 0);
        run_ticks(1, 2);
        chk("post_de2", s_de, 1);
        run_ticks(40, 2);
        @(negedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
